// File: rtl/alu_sequencer_n.sv
// rtl/alu_sequencer_n.sv - step-key driven N-bit ALU sequencer with accumulate mode and op counter
module alu_sequencer_n #(
   parameter int N     = 8,
   parameter int CNT_W = 8
) (
   input  logic             CLK50M,
   input  logic             RSTb,
   input  logic             STEP,
   input  logic [N-1:0]     INPUT,
   input  logic [2:0]       ALUcontrol,
   input  logic             ACC,
   output logic [N-1:0]     A_out,
   output logic [N-1:0]     B_out,
   output logic [N-1:0]     C_out,
   output logic             V,
   output logic             C,
   output logic             Neg,
   output logic             Z,
   output logic [1:0]       state,
   output logic             valid,
   output logic [CNT_W-1:0] opcnt
);

   typedef enum logic [1:0] {
      S_A   = 2'b00,
      S_B   = 2'b01,
      S_RES = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic             step_q;
   logic             strobe;
   logic [N-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
   logic [2:0]       op_q, op_d;
   logic             v_q, v_d, cf_q, cf_d, neg_q, neg_d, z_q, z_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N:0]       sum;
   logic [N-1:0]     alu_res;
   logic             alu_c, alu_v;

   // step_q resets high so a key held through reset release is not seen as a press
   assign strobe = STEP & ~step_q;

   always_comb begin
      sum     = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_q)
         3'b000, 3'b101: begin
            sum     = {1'b0, a_q} + {1'b0, INPUT}
                    + {{N{1'b0}}, (op_q == 3'b101) ? cf_q : 1'b0};
            alu_res = sum[N-1:0];
            alu_c   = sum[N];
            alu_v   = (a_q[N-1] == INPUT[N-1]) && (alu_res[N-1] != a_q[N-1]);
         end
         3'b001: begin
            sum     = {1'b0, a_q} + {1'b0, ~INPUT} + {{N{1'b0}}, 1'b1};
            alu_res = sum[N-1:0];
            alu_c   = sum[N];
            alu_v   = (a_q[N-1] != INPUT[N-1]) && (alu_res[N-1] != a_q[N-1]);
         end
         3'b010: alu_res = a_q & INPUT;
         3'b011: alu_res = a_q | INPUT;
         3'b100: alu_res = a_q ^ INPUT;
         3'b110: begin
            alu_res = {a_q[N-2:0], 1'b0};
            alu_c   = a_q[N-1];
            alu_v   = a_q[N-1] ^ a_q[N-2];
         end
         default: begin
            alu_res = {1'b0, a_q[N-1:1]};
            alu_c   = a_q[0];
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      op_d    = op_q;
      v_d     = v_q;
      cf_d    = cf_q;
      neg_d   = neg_q;
      z_d     = z_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_A: begin
            if (strobe) begin
               a_d     = INPUT;
               op_d    = ALUcontrol;
               state_d = S_B;
            end
         end
         S_B: begin
            if (strobe) begin
               b_d     = INPUT;
               c_d     = alu_res;
               v_d     = alu_v;
               cf_d    = alu_c;
               neg_d   = alu_res[N-1];
               z_d     = (alu_res == '0);
               cnt_d   = cnt_q + 1'b1;
               valid_d = 1'b1;
               state_d = S_RES;
            end
         end
         S_RES: begin
            if (strobe) begin
               a_d     = ACC ? c_q : INPUT;
               op_d    = ALUcontrol;
               valid_d = 1'b0;
               state_d = S_B;
            end
         end
         default: state_d = S_A;
      endcase
   end

   always_ff @(posedge CLK50M or negedge RSTb) begin
      if (!RSTb) begin
         state_q <= S_A;
         step_q  <= 1'b1;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         op_q    <= 3'b000;
         v_q     <= 1'b0;
         cf_q    <= 1'b0;
         neg_q   <= 1'b0;
         z_q     <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= STEP;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         op_q    <= op_d;
         v_q     <= v_d;
         cf_q    <= cf_d;
         neg_q   <= neg_d;
         z_q     <= z_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign A_out = a_q;
   assign B_out = b_q;
   assign C_out = c_q;
   assign V     = v_q;
   assign C     = cf_q;
   assign Neg   = neg_q;
   assign Z     = z_q;
   assign state = state_q;
   assign valid = valid_q;
   assign opcnt = cnt_q;

endmodule

// File: tb/tb_alu_sequencer_n.sv
// tb/tb_alu_sequencer_n.sv - directed self-checking bench for alu_sequencer_n (N=8 and N=16)
module tb_alu_sequencer_n;

   logic        clk;
   logic        rstb;
   logic        step;
   logic [7:0]  in8;
   logic [15:0] in16;
   logic [2:0]  opsel;
   logic        acc;

   logic [7:0]  a8, b8, c8;
   logic        v8, cf8, n8, z8, vld8;
   logic [1:0]  st8;
   logic [7:0]  cnt8;

   logic [15:0] a16, b16, c16;
   logic        v16, cf16, n16, z16, vld16;
   logic [1:0]  st16;
   logic [7:0]  cnt16;

   int tests = 0;
   int fails = 0;

   alu_sequencer_n #(.N(8), .CNT_W(8)) dut8 (
      .CLK50M(clk), .RSTb(rstb), .STEP(step), .INPUT(in8), .ALUcontrol(opsel), .ACC(acc),
      .A_out(a8), .B_out(b8), .C_out(c8), .V(v8), .C(cf8), .Neg(n8), .Z(z8),
      .state(st8), .valid(vld8), .opcnt(cnt8)
   );

   alu_sequencer_n #(.N(16), .CNT_W(8)) dut16 (
      .CLK50M(clk), .RSTb(rstb), .STEP(step), .INPUT(in16), .ALUcontrol(opsel), .ACC(acc),
      .A_out(a16), .B_out(b16), .C_out(c16), .V(v16), .C(cf16), .Neg(n16), .Z(z16),
      .state(st16), .valid(vld16), .opcnt(cnt16)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic press(input logic [7:0] v, input logic [2:0] op, input logic a);
      @(negedge clk);
      in8   = v;
      opsel = op;
      acc   = a;
      step  = 1'b1;
      @(negedge clk);
      step  = 1'b0;
   endtask

   task automatic test_reset;
      rstb = 1'b0; step = 1'b0; in8 = '0; in16 = '0; opsel = '0; acc = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if ({a8, b8, c8} !== 24'h0) begin fails++; $display("FAIL reset_abc got %h exp 0", {a8, b8, c8}); end
      tests++; if ({v8, cf8, n8, z8, vld8} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b exp 00000", {v8, cf8, n8, z8, vld8}); end
      tests++; if ({st8, cnt8} !== 10'h0) begin fails++; $display("FAIL reset_state_cnt got %h exp 0", {st8, cnt8}); end
      rstb = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_add_overflow;
      press(8'h7F, 3'b000, 1'b0);
      tests++; if (st8 !== 2'b01 || a8 !== 8'h7F) begin fails++; $display("FAIL add_capA got st=%b a=%h exp st=01 a=7f", st8, a8); end
      press(8'h01, 3'b000, 1'b0);
      tests++; if (c8 !== 8'h80 || b8 !== 8'h01) begin fails++; $display("FAIL add_result got c=%h b=%h exp c=80 b=01", c8, b8); end
      tests++; if ({v8, cf8, n8, z8} !== 4'b1010) begin fails++; $display("FAIL add_flags got %b exp 1010", {v8, cf8, n8, z8}); end
      tests++; if (vld8 !== 1'b1 || cnt8 !== 8'd1 || st8 !== 2'b10) begin fails++; $display("FAIL add_status got v=%b cnt=%0d st=%b exp 1 1 10", vld8, cnt8, st8); end
   endtask

   task automatic test_sub;
      press(8'h05, 3'b001, 1'b0);
      tests++; if (st8 !== 2'b01 || vld8 !== 1'b0 || a8 !== 8'h05) begin fails++; $display("FAIL sub_capA got st=%b vld=%b a=%h exp 01 0 05", st8, vld8, a8); end
      press(8'h05, 3'b001, 1'b0);
      tests++; if (c8 !== 8'h00 || {v8, cf8, n8, z8} !== 4'b0101) begin fails++; $display("FAIL sub_equal got c=%h f=%b exp 00 0101", c8, {v8, cf8, n8, z8}); end
      press(8'h00, 3'b001, 1'b0);
      press(8'h01, 3'b001, 1'b0);
      tests++; if (c8 !== 8'hFF || {v8, cf8, n8, z8} !== 4'b0010) begin fails++; $display("FAIL sub_borrow got c=%h f=%b exp ff 0010", c8, {v8, cf8, n8, z8}); end
      tests++; if (cnt8 !== 8'd3) begin fails++; $display("FAIL sub_cnt got %0d exp 3", cnt8); end
   endtask

   task automatic test_adc_chain;
      press(8'hFF, 3'b000, 1'b0);
      press(8'h01, 3'b000, 1'b0);
      tests++; if (c8 !== 8'h00 || {v8, cf8, n8, z8} !== 4'b0101) begin fails++; $display("FAIL chain_low got c=%h f=%b exp 00 0101", c8, {v8, cf8, n8, z8}); end
      press(8'h00, 3'b101, 1'b0);
      press(8'h00, 3'b101, 1'b0);
      tests++; if (c8 !== 8'h01 || {v8, cf8, n8, z8} !== 4'b0000) begin fails++; $display("FAIL chain_adc got c=%h f=%b exp 01 0000", c8, {v8, cf8, n8, z8}); end
   endtask

   task automatic test_logic_shift;
      press(8'hF0, 3'b100, 1'b0);
      press(8'hFF, 3'b100, 1'b0);
      tests++; if (c8 !== 8'h0F || {v8, cf8, n8, z8} !== 4'b0000) begin fails++; $display("FAIL xor got c=%h f=%b exp 0f 0000", c8, {v8, cf8, n8, z8}); end
      press(8'hC3, 3'b010, 1'b0);
      press(8'h3C, 3'b010, 1'b0);
      tests++; if (c8 !== 8'h00 || z8 !== 1'b1) begin fails++; $display("FAIL and got c=%h z=%b exp 00 1", c8, z8); end
      press(8'h81, 3'b111, 1'b0);
      press(8'hAA, 3'b111, 1'b0);
      tests++; if (c8 !== 8'h40 || {v8, cf8, n8, z8} !== 4'b0100) begin fails++; $display("FAIL shr got c=%h f=%b exp 40 0100", c8, {v8, cf8, n8, z8}); end
      press(8'h40, 3'b110, 1'b0);
      press(8'h00, 3'b110, 1'b0);
      tests++; if (c8 !== 8'h80 || {v8, cf8, n8, z8} !== 4'b1010) begin fails++; $display("FAIL shl_ovf got c=%h f=%b exp 80 1010", c8, {v8, cf8, n8, z8}); end
      tests++; if (cnt8 !== 8'd9) begin fails++; $display("FAIL logic_cnt got %0d exp 9", cnt8); end
   endtask

   task automatic test_accumulate;
      press(8'h03, 3'b000, 1'b0);
      press(8'h04, 3'b000, 1'b0);
      tests++; if (c8 !== 8'h07) begin fails++; $display("FAIL acc_base got %h exp 07", c8); end
      press(8'hEE, 3'b000, 1'b1);
      tests++; if (a8 !== 8'h07 || st8 !== 2'b01) begin fails++; $display("FAIL acc_capA got a=%h st=%b exp 07 01", a8, st8); end
      press(8'h05, 3'b000, 1'b1);
      tests++; if (c8 !== 8'h0C || cnt8 !== 8'd11) begin fails++; $display("FAIL acc_add got c=%h cnt=%0d exp 0c 11", c8, cnt8); end
      press(8'h55, 3'b110, 1'b1);
      tests++; if (a8 !== 8'h0C) begin fails++; $display("FAIL acc_shl_capA got %h exp 0c", a8); end
      press(8'h55, 3'b110, 1'b1);
      tests++; if (c8 !== 8'h18 || {v8, cf8, n8, z8} !== 4'b0000) begin fails++; $display("FAIL acc_shl got c=%h f=%b exp 18 0000", c8, {v8, cf8, n8, z8}); end
   endtask

   task automatic test_hold_and_reset_release;
      @(negedge clk);
      acc = 1'b0; in8 = 8'h11; step = 1'b1;
      repeat (1000) @(negedge clk);
      tests++; if (st8 !== 2'b01 || cnt8 !== 8'd12 || a8 !== 8'h11) begin fails++; $display("FAIL hold_one_step got st=%b cnt=%0d a=%h exp 01 12 11", st8, cnt8, a8); end
      rstb = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      repeat (10) @(negedge clk);
      tests++; if (st8 !== 2'b00) begin fails++; $display("FAIL held_through_reset got st=%b exp 00", st8); end
      step = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (st8 !== 2'b00) begin fails++; $display("FAIL release_no_step got st=%b exp 00", st8); end
      press(8'h22, 3'b000, 1'b0);
      tests++; if (st8 !== 2'b01 || a8 !== 8'h22) begin fails++; $display("FAIL repress got st=%b a=%h exp 01 22", st8, a8); end
   endtask

   task automatic test_async_reset;
      @(posedge clk);
      #3 rstb = 1'b0;
      #1;
      tests++; if ({a8, c8, st8, cnt8} !== 26'h0) begin fails++; $display("FAIL async_reset got a=%h c=%h st=%b cnt=%0d exp all 0", a8, c8, st8, cnt8); end
      @(negedge clk);
      rstb = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_wide;
      in16 = 16'h7FFF;
      press(8'h00, 3'b000, 1'b0);
      in16 = 16'h0001;
      press(8'h00, 3'b000, 1'b0);
      tests++; if (c16 !== 16'h8000 || {v16, cf16, n16, z16} !== 4'b1010) begin fails++; $display("FAIL wide_add got c=%h f=%b exp 8000 1010", c16, {v16, cf16, n16, z16}); end
      tests++; if (vld16 !== 1'b1 || st16 !== 2'b10 || cnt16 !== 8'd1 || a16 !== 16'h7FFF || b16 !== 16'h0001) begin fails++; $display("FAIL wide_status got vld=%b st=%b cnt=%0d a=%h b=%h", vld16, st16, cnt16, a16, b16); end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_sub();
      test_adc_chain();
      test_logic_shift();
      test_accumulate();
      test_hold_and_reset_release();
      test_async_reset();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
